// File: rtl/sb_branch_n.sv
// N-way token branch stage: DEPTH-entry FIFO feeding a one-token output register
// steered to one of NCH channels. Optional feature macro: SB_BYPASS_EN (empty-stage bypass).
module sb_branch_n #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned SEL_W  = 1,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NODE_W = 16,
  parameter int unsigned GEN_W  = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [NODE_W-1:0]      in_node,
  input  logic [GEN_W-1:0]       in_gen,
  input  logic [DATA_W-1:0]      in_opr,
  input  logic                   hold,
  output logic [NCH-1:0]         out_valid,
  input  logic [NCH-1:0]         out_ready,
  output logic [NODE_W-1:0]      out_node,
  output logic [GEN_W-1:0]       out_gen,
  output logic [DATA_W-1:0]      out_opr,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   err_sel,
  output logic [7:0]             err_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [SEL_W:0]   NCH_L   = (SEL_W+1)'(NCH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [NODE_W-1:0] node;
    logic [GEN_W-1:0]  gen;
    logic [DATA_W-1:0] opr;
  } tok_t;

  tok_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  tok_t             or_q, or_d;
  logic [NCH-1:0]   out_valid_q, out_valid_d;
  logic             err_sel_q, err_sel_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  tok_t in_tok;
  tok_t head;
  logic push;
  logic fifo_empty;
  logic complete;
  logic or_free;
  logic pop;
  logic head_legal;
  logic load_fifo;
  logic discard;
  logic bypass;
  logic fifo_wr;

  assign in_tok     = '{sel: in_sel, node: in_node, gen: in_gen, opr: in_opr};
  assign head       = mem_q[rd_ptr_q];

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready   = rst & (level_q < DEPTH_L);
  assign push       = in_valid & in_ready;
  assign fifo_empty = (level_q == '0);

  // Only the selected channel's ready bit can complete the held token.
  assign complete   = |(out_valid_q & out_ready);
  assign or_free    = ~(|out_valid_q) | complete;
  assign pop        = or_free & ~hold & ~fifo_empty;
  assign head_legal = ({1'b0, head.sel} < NCH_L);
  assign load_fifo  = pop & head_legal;
  assign discard    = pop & ~head_legal;

`ifdef SB_BYPASS_EN
  logic in_legal;
  assign in_legal = ({1'b0, in_sel} < NCH_L);
  // Legal token into an idle stage skips the FIFO entirely.
  assign bypass   = push & fifo_empty & or_free & ~hold & in_legal;
`else
  assign bypass   = 1'b0;
`endif

  assign fifo_wr = push & ~bypass;

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (fifo_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({fifo_wr, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Output register: load has priority over clearing on completion
  always_comb begin
    or_d        = or_q;
    out_valid_d = out_valid_q;
    if (complete) out_valid_d = '0;
    if (load_fifo) begin
      or_d        = head;
      out_valid_d = NCH'(1) << head.sel;
    end else if (bypass) begin
      or_d        = in_tok;
      out_valid_d = NCH'(1) << in_tok.sel;
    end
  end

  // Illegal-select reporting
  always_comb begin
    err_sel_d = discard;
    err_cnt_d = err_cnt_q;
    if (discard && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      or_q        <= '0;
      out_valid_q <= '0;
      err_sel_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      or_q        <= or_d;
      out_valid_q <= out_valid_d;
      err_sel_q   <= err_sel_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Storage needs no reset: entries are only read below the occupancy level.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= in_tok;
  end

  assign out_valid = out_valid_q;
  assign out_sel   = or_q.sel;
  assign out_node  = or_q.node;
  assign out_gen   = or_q.gen;
  assign out_opr   = or_q.opr;
  assign err_sel   = err_sel_q;
  assign err_cnt   = err_cnt_q;
  assign level     = level_q;

endmodule

// File: tb/tb_sb_branch_n.sv
// Directed self-checking bench for sb_branch_n (NCH=3, DEPTH=4).
module tb_sb_branch_n;

  localparam int unsigned NCH    = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NODE_W = 16;
  localparam int unsigned GEN_W  = 12;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  in_sel;
  logic [NODE_W-1:0] in_node;
  logic [GEN_W-1:0]  in_gen;
  logic [DATA_W-1:0] in_opr;
  logic              hold;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [NODE_W-1:0] out_node;
  logic [GEN_W-1:0]  out_gen;
  logic [DATA_W-1:0] out_opr;
  logic [SEL_W-1:0]  out_sel;
  logic              err_sel;
  logic [7:0]        err_cnt;
  logic [2:0]        level;

  int n_chk = 0;
  int n_err = 0;
  int err_pulses = 0;

  logic [SEL_W-1:0]  q_sel[$];
  logic [NODE_W-1:0] q_node[$];

  sb_branch_n #(
    .NCH(NCH), .SEL_W(SEL_W), .DEPTH(DEPTH),
    .NODE_W(NODE_W), .GEN_W(GEN_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_node(in_node), .in_gen(in_gen), .in_opr(in_opr),
    .hold(hold),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_node(out_node), .out_gen(out_gen), .out_opr(out_opr), .out_sel(out_sel),
    .err_sel(err_sel), .err_cnt(err_cnt), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one token until accepted; legal tokens are queued as expected output.
  task automatic push_tok(input logic [SEL_W-1:0] sel, input logic [NODE_W-1:0] node);
    logic acc;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_node  = node;
    in_gen   = GEN_W'(node);
    in_opr   = {16'hC0DE, node};
    for (int t = 0; t < 64 && !done; t++) begin
      acc = in_ready;
      if (acc && (sel < SEL_W'(NCH))) begin
        q_sel.push_back(sel);
        q_node.push_back(node);
      end
      cyc();
      if (acc) done = 1'b1;
    end
    if (!done) check("push_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  // Consume n tokens, comparing each completion against the expected queue.
  task automatic drain(input int n, input bit rnd, input int budget);
    int         got;
    int         cycles;
    logic [2:0] rdy;
    logic [2:0] ov_exp;
    got    = 0;
    cycles = 0;
    while (got < n && cycles < budget) begin
      if (err_sel) err_pulses++;
      rdy       = rnd ? 3'($urandom_range(0, 7)) : 3'b111;
      out_ready = rdy;
      if ((out_valid & rdy) != 3'b000) begin
        ov_exp = 3'b001 << q_sel[0];
        check("drain_valid", 64'(out_valid), 64'(ov_exp));
        check("drain_node", 64'(out_node), 64'(q_node[0]));
        void'(q_sel.pop_front());
        void'(q_node.pop_front());
        got++;
      end
      cyc();
      cycles++;
    end
    if (got < n) check("drain_timeout", 64'(got), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_node = '0; in_gen = '0; in_opr = '0;
    hold = 1'b0; out_ready = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_node", 64'(out_node), 64'd0);
    check("rst_out_sel", 64'(out_sel), 64'd0);
    check("rst_err", 64'({err_sel, err_cnt}), 64'd0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Single token latency and fields
    out_ready = 3'b111;
    in_valid = 1'b1; in_sel = 2'd1; in_node = 16'h0012; in_gen = 12'h003; in_opr = 32'hDEADBEEF;
    cyc();
    in_valid = 1'b0;
`ifndef SB_BYPASS_EN
    check("lat_not_yet", 64'(out_valid), 64'd0);
    check("lat_level1", 64'(level), 64'd1);
    cyc();
`endif
    check("lat_valid", 64'(out_valid), 64'b010);
    check("lat_sel", 64'(out_sel), 64'd1);
    check("lat_node", 64'(out_node), 64'h0012);
    check("lat_gen", 64'(out_gen), 64'h003);
    check("lat_opr", 64'(out_opr), 64'hDEADBEEF);
    check("lat_level0", 64'(level), 64'd0);
    cyc();
    check("lat_one_cycle", 64'(out_valid), 64'd0);
    check("lat_keep_node", 64'(out_node), 64'h0012);

    // Fill to full with a stalled output; only the selected ready bit counts
    out_ready = 3'b000;
    push_tok(2'd2, 16'h00A0);
    push_tok(2'd0, 16'h00A1);
    push_tok(2'd1, 16'h00A2);
    push_tok(2'd2, 16'h00A3);
    push_tok(2'd0, 16'h00A4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_level", 64'(level), 64'd4);
    check("full_valid", 64'(out_valid), 64'b100);
    out_ready = 3'b011;
    cyc();
    check("other_rdy_ignored", 64'(out_valid), 64'b100);
    check("other_rdy_level", 64'(level), 64'd4);
    in_valid = 1'b1; in_sel = 2'd1; in_node = 16'h00A5; in_gen = 12'h0A5; in_opr = 32'hC0DE00A5;
    out_ready = 3'b100;
    cyc();
    void'(q_sel.pop_front());
    void'(q_node.pop_front());
    check("pop_in_ready_next", 64'(in_ready), 64'd1);
    check("pop_level", 64'(level), 64'd3);
    check("pop_next_valid", 64'(out_valid), 64'b001);
    check("pop_next_node", 64'(out_node), 64'h00A1);
    out_ready = 3'b000;
    q_sel.push_back(2'd1);
    q_node.push_back(16'h00A5);
    cyc();
    in_valid = 1'b0;
    check("refill_level", 64'(level), 64'd4);
    drain(5, 1'b0, 100);
    cyc();
    check("full_drained", 64'(level), 64'd0);

    // Concurrent stream with random backpressure
    fork
      begin
        for (int i = 0; i < 16; i++) push_tok(SEL_W'(i % 2), 16'h0100 + 16'(i));
      end
      begin
        drain(16, 1'b1, 600);
      end
    join
    check("stream_empty_q", 64'(q_sel.size()), 64'd0);

    // Illegal select between two legal tokens
    out_ready = 3'b000;
    cyc(); cyc();
    err_pulses = 0;
    push_tok(2'd0, 16'h0040);
    push_tok(2'd3, 16'h0041);
    push_tok(2'd1, 16'h0042);
    drain(2, 1'b0, 50);
    for (int i = 0; i < 4; i++) begin
      if (err_sel) err_pulses++;
      cyc();
    end
    check("illegal_pulses", 64'(err_pulses), 64'd1);
    check("illegal_cnt", 64'(err_cnt), 64'd1);
    check("illegal_err_low", 64'(err_sel), 64'd0);
    for (int i = 0; i < 300; i++) push_tok(2'd3, 16'(i));
    for (int i = 0; i < 8; i++) cyc();
    check("err_cnt_sat", 64'(err_cnt), 64'd255);
    check("sat_level", 64'(level), 64'd0);
    check("sat_no_valid", 64'(out_valid), 64'd0);

    // Hold: current token completes, no new loads until released
    out_ready = 3'b000;
    push_tok(2'd0, 16'h0050);
    push_tok(2'd1, 16'h0051);
    push_tok(2'd2, 16'h0052);
    push_tok(2'd0, 16'h0053);
    check("hold_level3", 64'(level), 64'd3);
    check("hold_or_valid", 64'(out_valid), 64'b001);
    hold = 1'b1;
    out_ready = 3'b111;
    cyc();
    void'(q_sel.pop_front());
    void'(q_node.pop_front());
    for (int i = 0; i < 3; i++) begin
      check("hold_blocked", 64'(out_valid), 64'd0);
      check("hold_level", 64'(level), 64'd3);
      cyc();
    end
    hold = 1'b0;
    drain(3, 1'b0, 50);

    // Reset in the middle of traffic
    out_ready = 3'b000;
    cyc();
    push_tok(2'd2, 16'h0060);
    push_tok(2'd1, 16'h0061);
    push_tok(2'd0, 16'h0062);
    push_tok(2'd1, 16'h0063);
    check("mid_level3", 64'(level), 64'd3);
    check("mid_valid", 64'(out_valid), 64'b100);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_node", 64'(out_node), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_errcnt", 64'(err_cnt), 64'd0);
    q_sel.delete();
    q_node.delete();
    cyc(); cyc();
    rst = 1'b1;
    out_ready = 3'b111;
    cyc();
    check("post_rst_ready", 64'(in_ready), 64'd1);
    check("post_rst_level", 64'(level), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("no_stale", 64'(out_valid), 64'd0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
